// File: rtl/decode_reg_block.sv
// Decode/writeback stage: 15-entry register file, source/destination selection,
// next-PC choice and illegal-use detection. Optional macro: WB_BYPASS_EN.
module decode_reg_block #(
  parameter logic [63:0] RSP_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnd,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        write_enable,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic [63:0] valP,
  input  logic [63:0] valC,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] PC_updated,
  output logic        reg_error
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;
  localparam int         NREGS    = 15;

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [63:0] regs_q [NREGS];
  logic [63:0] regs_d [NREGS];

  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic        need_ra;
  logic        need_rb;
  logic        wb_en;
  logic        ifun_unused;

  // ifun only selects ALU op / condition downstream; it does not affect decode.
  assign ifun_unused = ^ifun;

  always_comb begin
    src_a   = RNONE;
    src_b   = RNONE;
    dst_e   = RNONE;
    dst_m   = RNONE;
    need_ra = 1'b0;
    need_rb = 1'b0;
    case (icode)
      I_RRMOVQ: begin
        src_a   = rA;
        dst_e   = cnd ? rB : RNONE;
        need_ra = 1'b1;
        need_rb = 1'b1;
      end
      I_IRMOVQ: begin
        dst_e   = rB;
        need_rb = 1'b1;
      end
      I_RMMOVQ: begin
        src_a   = rA;
        src_b   = rB;
        need_ra = 1'b1;
        need_rb = 1'b1;
      end
      I_MRMOVQ: begin
        src_b   = rB;
        dst_m   = rA;
        need_ra = 1'b1;
        need_rb = 1'b1;
      end
      I_OPQ: begin
        src_a   = rA;
        src_b   = rB;
        dst_e   = rB;
        need_ra = 1'b1;
        need_rb = 1'b1;
      end
      I_CALL: begin
        src_b = RSP;
        dst_e = RSP;
      end
      I_RET: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
      end
      I_PUSHQ: begin
        src_a   = rA;
        src_b   = RSP;
        dst_e   = RSP;
        need_ra = 1'b1;
      end
      I_POPQ: begin
        src_a   = RSP;
        src_b   = RSP;
        dst_e   = RSP;
        dst_m   = rA;
        need_ra = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    reg_error = (icode > I_POPQ)
              | (need_ra & (rA == RNONE))
              | (need_rb & (rB == RNONE));
  end

  assign wb_en = write_enable & ~reg_error;

  always_comb begin
    PC_updated = valP;
    if (!reg_error) begin
      case (icode)
        I_CALL:  PC_updated = valC;
        I_JXX:   PC_updated = cnd ? valC : valP;
        I_RET:   PC_updated = valM;
        default: PC_updated = valP;
      endcase
    end
  end

  // valE first, then valM, so popq %rsp leaves the memory value in %rsp.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wb_en && (dst_e == 4'(i))) regs_d[i] = valE;
      if (wb_en && (dst_m == 4'(i))) regs_d[i] = valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 4) ? RSP_RESET : 64'h0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  logic [63:0] rd_a;
  logic [63:0] rd_b;

  // RNONE never matches a loop index, so it reads as zero.
  always_comb begin
    rd_a = 64'h0;
    rd_b = 64'h0;
    for (int i = 0; i < NREGS; i++) begin
      if (src_a == 4'(i)) rd_a = regs_q[i];
      if (src_b == 4'(i)) rd_b = regs_q[i];
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    valA = rd_a;
    valB = rd_b;
    if (wb_en && (src_a != RNONE)) begin
      if (src_a == dst_m)      valA = valM;
      else if (src_a == dst_e) valA = valE;
    end
    if (wb_en && (src_b != RNONE)) begin
      if (src_b == dst_m)      valB = valM;
      else if (src_b == dst_e) valB = valE;
    end
  end
`else
  always_comb begin
    valA = rd_a;
    valB = rd_b;
  end
`endif

endmodule

// File: tb/tb_decode_reg_block.sv
// Randomized and directed bench for decode_reg_block against a behavioural
// register-file model built from the instruction decode rules.
module tb_decode_reg_block;

  localparam logic [63:0] RSP_INIT = 64'h0000_0000_0000_1000;

  logic        clk;
  logic        clk_run;
  logic        rst_n;
  logic        cnd;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        write_enable;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [63:0] valP;
  logic [63:0] valC;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] PC_updated;
  logic        reg_error;

  int n_checks;
  int n_pass;

  logic [63:0] model_r [15];
  logic [63:0] exp_q [$];

  decode_reg_block #(.RSP_RESET(RSP_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .cnd(cnd), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .write_enable(write_enable),
    .valE(valE), .valM(valM), .valP(valP), .valC(valC),
    .valA(valA), .valB(valB), .PC_updated(PC_updated), .reg_error(reg_error)
  );

  // clock / reset
  initial begin
    clk     = 1'b0;
    clk_run = 1'b1;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // reference model
  function automatic void model_reset();
    for (int i = 0; i < 15; i++) model_r[i] = (i == 4) ? RSP_INIT : 64'h0;
  endfunction

  function automatic bit m_err(input int ic, input int ra, input int rb);
    bit bad_a;
    bit bad_b;
    bad_a = (ic inside {2, 4, 5, 6, 10, 11}) && (ra == 15);
    bad_b = (ic inside {2, 3, 4, 5, 6}) && (rb == 15);
    return (ic > 11) || bad_a || bad_b;
  endfunction

  function automatic int m_src_a(input int ic, input int ra);
    if (ic inside {2, 4, 6, 10}) return ra;
    if (ic inside {9, 11}) return 4;
    return 15;
  endfunction

  function automatic int m_src_b(input int ic, input int rb);
    if (ic inside {4, 5, 6}) return rb;
    if (ic inside {8, 9, 10, 11}) return 4;
    return 15;
  endfunction

  function automatic int m_dst_e(input int ic, input int rb, input bit c);
    if (ic inside {3, 6}) return rb;
    if (ic == 2 && c) return rb;
    if (ic inside {8, 9, 10, 11}) return 4;
    return 15;
  endfunction

  function automatic int m_dst_m(input int ic, input int ra);
    if (ic inside {5, 11}) return ra;
    return 15;
  endfunction

  function automatic logic [63:0] m_read(input int src, input bit wb, input int de,
                                         input int dm, input logic [63:0] ve,
                                         input logic [63:0] vm);
    if (src == 15) return 64'h0;
`ifdef WB_BYPASS_EN
    if (wb && src == dm) return vm;
    if (wb && src == de) return ve;
`endif
    return model_r[src];
  endfunction

  function automatic logic [63:0] m_pc(input int ic, input bit c, input bit err,
                                       input logic [63:0] vp, input logic [63:0] vc,
                                       input logic [63:0] vm);
    if (err) return vp;
    if (ic == 8) return vc;
    if (ic == 7 && c) return vc;
    if (ic == 9) return vm;
    return vp;
  endfunction

  // Compare the combinational outputs against the model for the current inputs.
  task automatic check_outputs(input string tag);
    int  ic, ra, rb, de, dm;
    bit  err, wb;
    ic  = int'(icode);
    ra  = int'(rA);
    rb  = int'(rB);
    err = m_err(ic, ra, rb);
    wb  = write_enable && !err;
    de  = m_dst_e(ic, rb, cnd);
    dm  = m_dst_m(ic, ra);
    check({tag, ".err"}, 64'(reg_error), 64'(err));
    check({tag, ".pc"}, PC_updated, m_pc(ic, cnd, err, valP, valC, valM));
    check({tag, ".valA"}, valA, m_read(m_src_a(ic, ra), wb, de, dm, valE, valM));
    check({tag, ".valB"}, valB, m_read(m_src_b(ic, rb), wb, de, dm, valE, valM));
  endtask

  task automatic model_commit();
    int  ic, ra, rb, de, dm;
    ic = int'(icode);
    ra = int'(rA);
    rb = int'(rB);
    if (!rst_n || !write_enable || m_err(ic, ra, rb)) return;
    de = m_dst_e(ic, rb, cnd);
    dm = m_dst_m(ic, ra);
    if (de != 15) model_r[de] = valE;
    if (dm != 15) model_r[dm] = valM;
  endtask

  // driver tasks
  task automatic apply(input string tag, input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic we, input logic c,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [63:0] vp, input logic [63:0] vc);
    @(negedge clk);
    icode = ic; ifun = 4'($urandom_range(0, 15)); rA = ra; rB = rb;
    write_enable = we; cnd = c; valE = ve; valM = vm; valP = vp; valC = vc;
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // Reads every register through valA without needing a clock edge.
  task automatic read_all(input string tag);
    for (int i = 0; i < 15; i++) exp_q.push_back(model_r[i]);
    for (int i = 0; i < 15; i++) begin
      icode = 4'h6; rA = 4'(i); rB = 4'(i); write_enable = 1'b0;
      #1;
      check($sformatf("%s.R%0d", tag, i), valA, exp_q.pop_front());
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0; cnd = 1'b0; icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
    write_enable = 1'b0; valE = '0; valM = '0; valP = '0; valC = '0;
    model_reset();
    #2;
    read_all("reset");
    // write attempted while in reset must be blocked
    apply("rst_blk", 4'h3, 4'hF, 4'd7, 1'b1, 1'b0, 64'hDEAD, 64'h0, 64'h8, 64'h0);
    read_all("rst_blk_rd");
    @(negedge clk);
    rst_n = 1'b1;

    apply("irmov", 4'h3, 4'hF, 4'd14, 1'b1, 1'b0, 64'd137, 64'h0, 64'd10, 64'd137);
    apply("opq", 4'h6, 4'd14, 4'd14, 1'b0, 1'b0, 64'h0, 64'h0, 64'd12, 64'h0);
    check("opq.valA137", valA, 64'd137);

    apply("cmov0", 4'h2, 4'd3, 4'd5, 1'b1, 1'b0, 64'd114, 64'h0, 64'd14, 64'h0);
    apply("rd5a", 4'h6, 4'd5, 4'd5, 1'b0, 1'b0, 64'h0, 64'h0, 64'd16, 64'h0);
    apply("cmov1", 4'h2, 4'd3, 4'd5, 1'b1, 1'b1, 64'd114, 64'h0, 64'd18, 64'h0);
    apply("rd5b", 4'h6, 4'd5, 4'd5, 1'b0, 1'b0, 64'h0, 64'h0, 64'd20, 64'h0);
    check("rd5b.valB114", valB, 64'd114);

    apply("jxx1", 4'h7, 4'hF, 4'hF, 1'b1, 1'b1, 64'h0, 64'h0, 64'd61, 64'd100);
    apply("jxx0", 4'h7, 4'hF, 4'hF, 1'b1, 1'b0, 64'h0, 64'h0, 64'd61, 64'd100);

    apply("popsp", 4'hB, 4'd4, 4'hF, 1'b1, 1'b0, 64'd8, 64'd72, 64'd63, 64'h0);
    apply("ret", 4'h9, 4'hF, 4'hF, 1'b0, 1'b0, 64'd80, 64'd92, 64'd64, 64'h0);
    check("ret.pc92", PC_updated, 64'd92);

    apply("ill12", 4'hC, 4'd1, 4'd2, 1'b1, 1'b1, 64'h55, 64'h66, 64'd70, 64'd99);
    apply("opq_rbF", 4'h6, 4'd1, 4'hF, 1'b1, 1'b0, 64'h77, 64'h0, 64'd72, 64'h0);
    read_all("after_err");

    for (int n = 0; n < 300; n++) begin
      logic [3:0] ic;
      ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                       : 4'($urandom_range(0, 11));
      apply("rand", ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            rnd64(), rnd64(), rnd64(), rnd64());
    end
    read_all("rand_rd");

    // asynchronous reset with the clock stopped low
    @(negedge clk);
    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    read_all("async_rst");
    rst_n = 1'b1;
    #2;
    clk_run = 1'b1;
    apply("post_rst", 4'hA, 4'd2, 4'hF, 1'b1, 1'b0, 64'hABCD, 64'h0, 64'd4, 64'h0);
    read_all("post_rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_reg_block.md
DECODE_REG_BLOCK -- requirements
Module: decode_reg_block

Interface
REQ-001 Parameter RSP_RESET, default 64'h0: reset value of register 4 (%rsp); all other registers reset to 0.
REQ-002 Port clk, input, 1: single clock; all register writes occur on its rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port cnd, input, 1: condition flag from execute; qualifies cmovXX writeback and jXX PC selection.
REQ-005 Port icode, input, 4: instruction code (0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, 10 pushq, 11 popq).
REQ-006 Port ifun, input, 4: function code; no effect on decode or writeback.
REQ-007 Ports rA and rB, input, 4 each: register specifiers; 4'hF = RNONE.
REQ-008 Port write_enable, input, 1: writeback enable for the current instruction.
REQ-009 Ports valE, valM, valP, valC, input, 64 each: ALU result, memory read data, fall-through PC, constant word.
REQ-010 Ports valA and valB, output, 64 each: register read data.
REQ-011 Port PC_updated, output, 64: next PC.
REQ-012 Port reg_error, output, 1: illegal instruction/register-use flag.

Function
REQ-013 Register file SHALL hold 15 x 64-bit registers, indices 0-14; index 15 SHALL never be written.
REQ-014 srcA: rA for icode 2, 4, 6, 10; 4 for icode 9 and 11; else F.
REQ-015 srcB: rB for icode 4, 5, 6; 4 for icode 8, 9, 10, 11; else F.
REQ-016 valA/valB SHALL be combinational reads of srcA/srcB, returning 0 when the source is F.
REQ-017 dstE: rB for icode 3 and 6; rB for icode 2 only when cnd=1; 4 for icode 8, 9, 10, 11; else F.
REQ-018 dstM: rA for icode 5 and 11; else F.
REQ-019 On rising clk with write_enable=1 and reg_error=0: R[dstE]<=valE if dstE!=F, and R[dstM]<=valM if dstM!=F.
REQ-020 If dstE==dstM (popq %rsp), the valM write SHALL win.
REQ-021 write_enable=0 or reg_error=1 SHALL suppress all writes.
REQ-022 PC_updated (combinational) SHALL be:
- valC for call;
- valC for jXX with cnd=1;
- valM for ret;
- valP otherwise.
REQ-023 reg_error SHALL assert combinationally when:
- icode>11; or
- a required rA is F (icode 2, 4, 6, 10, 11, and 5 as dstM); or
- a required rB is F (icode 2, 3, 4, 5, 6).
- When asserted, PC_updated SHALL still be valP.

Reset
REQ-024 rst_n=0 SHALL immediately clear registers 0-14 to 0, except register 4, which takes RSP_RESET, regardless of clk.
REQ-025 Writes SHALL be blocked while rst_n=0; the first write occurs at the first rising clk after deassertion.
REQ-026 Outputs SHALL remain combinational during reset, reflecting reset register contents.

Configuration
REQ-027 Macro WB_BYPASS_EN, when defined:
- valA/valB SHALL return the pending write data (valM over valE) when srcA/srcB equals an active dstM/dstE with write_enable=1 and reg_error=0.
- Without the macro, valA/valB SHALL return only stored register contents.

Verification
REQ-028 Reset, then icode=3, rB=14, valE=137, write_enable=1, rising clk -> R14=137; then icode=6, rA=14, rB=14 -> valA=valB=137.
REQ-029 icode=2, rA=3, rB=5, valE=114, cnd=0, clk -> R5 unchanged; same with cnd=1 -> R5=114.
REQ-030 icode=7, valC=100, valP=61: cnd=1 -> PC_updated=100; cnd=0 -> PC_updated=61.
REQ-031 icode=11, rA=4, valE=8, valM=72, clk -> R4=72; icode=9, valM=92 -> PC_updated=92, valA=valB=72.
REQ-032 icode=12, or icode=6 with rB=F -> reg_error=1, no register changes after clk, PC_updated=valP.
REQ-033 Assert rst_n=0 mid-sequence with clk held -> all registers 0 (R4=RSP_RESET) immediately.
